// File: rtl/radix_4_dot_ctrl_pkg.sv
// Shared definitions for the radix-4 dot-product sequencer: operand/product widths
// and the controller state encoding.
package radix_4_pkg;

    localparam int OPND_W = 8;
    localparam int PROD_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        ACC   = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/radix_4_dot_ctrl_if.sv
// Bundle of operand stream, multiplier control and result stream signals.
// slave = the sequencer, master = whatever surrounds it.
interface radix_4_dot_ctrl_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
);
    import radix_4_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [OPND_W-1:0] in_x;
    logic signed [OPND_W-1:0] in_y;
    logic                     in_last;

    logic                     mul_reset;
    logic                     mul_start;
    logic signed [OPND_W-1:0] mul_x;
    logic signed [OPND_W-1:0] mul_y;
    logic signed [PROD_W-1:0] mul_product;
    logic                     mul_ready;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]         out_count;
    logic                     out_err;
    logic                     out_sat;

    modport slave (
        input  in_valid, in_x, in_y, in_last, mul_product, mul_ready, out_ready,
        output in_ready, mul_reset, mul_start, mul_x, mul_y,
               out_valid, out_sum, out_count, out_err, out_sat
    );

    modport master (
        output in_valid, in_x, in_y, in_last, mul_product, mul_ready, out_ready,
        input  in_ready, mul_reset, mul_start, mul_x, mul_y,
               out_valid, out_sum, out_count, out_err, out_sat
    );

endinterface

// File: rtl/radix_4_dot_ctrl_acc.sv
// Dot-product accumulator: sign-extends each product, adds it, counts terms.
// DOT_SAT_EN selects signed saturation (with sticky out_sat) instead of wrap.
module radix_4_dot_acc
    import radix_4_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     add_en,
    input  logic                     clear,
    input  logic signed [PROD_W-1:0] product,
    output logic signed [ACC_W-1:0]  acc,
    output logic [CNT_W-1:0]         count,
    output logic                     sat
);

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;

    assign prod_ext[PROD_W-1:0] = product;
    generate
        for (genvar gi = PROD_W; gi < ACC_W; gi++) begin : g_sext
            assign prod_ext[gi] = product[PROD_W-1];
        end
    endgenerate

`ifdef DOT_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] sum_wide;
    logic                  sat_reg, sat_next;

    // One guard bit: overflow shows up as the top two bits disagreeing.
    assign sum_wide = {acc_reg[ACC_W-1], acc_reg} + {prod_ext[ACC_W-1], prod_ext};

    always_comb begin
        acc_next = acc_reg;
        sat_next = sat_reg;
        if (clear) begin
            acc_next = '0;
            sat_next = 1'b0;
        end else if (add_en) begin
            if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
                acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
                sat_next = 1'b1;
            end else begin
                acc_next = sum_wide[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) sat_reg <= 1'b0;
        else       sat_reg <= sat_next;
    end

    assign sat = sat_reg;
`else
    always_comb begin
        acc_next = acc_reg;
        if (clear)       acc_next = '0;
        else if (add_en) acc_next = acc_reg + prod_ext;
    end

    assign sat = 1'b0;
`endif

    always_comb begin
        cnt_next = cnt_reg;
        if (clear)
            cnt_next = '0;
        else if (add_en && (cnt_reg != {CNT_W{1'b1}}))
            cnt_next = cnt_reg + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_next;
        end
    end

    assign acc   = acc_reg;
    assign count = cnt_reg;

endmodule

// File: rtl/radix_4_dot_ctrl.sv
// Sequencer around an external radix-4 8x8 multiplier: one multiply per operand
// pair, results accumulated into a dot product emitted after the in_last pair.
module radix_4_dot_ctrl
    import radix_4_pkg::*;
#(
    parameter int ACC_W   = 24,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 31
) (
    input  logic              clock,
    input  logic              reset,
    radix_4_dot_ctrl_if.slave bus
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t                   state_reg, state_next;
    logic signed [OPND_W-1:0] x_reg, y_reg;
    logic                     last_reg;
    logic                     err_reg, err_next;
    logic [TMR_W-1:0]         timer_reg, timer_next;
    logic                     take_pair;
    logic                     acc_en, acc_clear;
    logic signed [ACC_W-1:0]  acc_sum;
    logic [CNT_W-1:0]         acc_count;
    logic                     acc_sat;

    assign take_pair = (state_reg == IDLE) && bus.in_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            last_reg  <= 1'b0;
            timer_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            err_reg   <= err_next;
            if (take_pair) begin
                x_reg    <= bus.in_x;
                y_reg    <= bus.in_y;
                last_reg <= bus.in_last;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        err_next   = err_reg;
        acc_en     = 1'b0;
        acc_clear  = 1'b0;
        case (state_reg)
            IDLE:  if (bus.in_valid) state_next = LOAD;
            LOAD:  state_next = START;
            START: begin
                state_next = WAIT;
                timer_next = '0;
            end
            WAIT: begin
                if (bus.mul_ready) begin
                    state_next = ACC;
                end else if (timer_reg == TMR_W'(TIMEOUT)) begin
                    // A dead multiply contributes nothing; the dot product still completes.
                    err_next   = 1'b1;
                    state_next = last_reg ? DONE : IDLE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            ACC: begin
                acc_en     = 1'b1;
                state_next = last_reg ? DONE : IDLE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    acc_clear  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    radix_4_dot_acc #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_acc (
        .clock   (clock),
        .reset   (reset),
        .add_en  (acc_en),
        .clear   (acc_clear),
        .product (bus.mul_product),
        .acc     (acc_sum),
        .count   (acc_count),
        .sat     (acc_sat)
    );

    assign bus.in_ready  = (state_reg == IDLE) && !reset;
    assign bus.mul_reset = reset || (state_reg == LOAD);
    assign bus.mul_start = (state_reg == START);
    assign bus.mul_x     = x_reg;
    assign bus.mul_y     = y_reg;
    assign bus.out_valid = (state_reg == DONE);
    assign bus.out_sum   = acc_sum;
    assign bus.out_count = acc_count;
    assign bus.out_err   = err_reg;
    assign bus.out_sat   = acc_sat;

endmodule
